// File: rtl/alu_fwd_ctrl.sv
// Forwarding and load-use hazard controller for the EX-stage ALU operand muxes.
// Tracks in-flight destination registers and emits registered operand selects.
//
// state  | meaning
// RUN    | normal issue, no load-use bubble in flight
// LSTALL | one load-use bubble being inserted; held while mem_stall=1
module alu_fwd_ctrl #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             mem_stall,
  input  logic             ex_flush,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_f,
  output logic             stall_d,
  output logic             bubble_e,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, LSTALL} state_t;

  state_t state_q, state_d;

  // The WB slot is not stored: its producer writes a write-before-read
  // register file this cycle, so it never influences a select or hazard.
  logic             ex_v, ex_rw, ex_mr;
  logic [REG_W-1:0] ex_rd;
  logic             mem_v, mem_rw;
  logic [REG_W-1:0] mem_rd;

  logic       adv, hz, ex_load, ex_prod, mem_prod, cnt_inc;
  logic       rs1_ex_hit, rs2_ex_hit;
  logic [1:0] sel_a_d, sel_b_d;

  assign adv      = !mem_stall;
  assign ex_prod  = ex_v && ex_rw && (ex_rd != '0);
  assign mem_prod = mem_v && mem_rw && (mem_rd != '0);

  assign rs1_ex_hit = id_rs1_used && (id_rs1 == ex_rd);
  assign rs2_ex_hit = id_rs2_used && (id_rs2 == ex_rd);

  assign hz      = id_valid && ex_prod && ex_mr && (rs1_ex_hit || rs2_ex_hit);
  assign ex_load = id_valid && !hz && !ex_flush;

  assign stall_f  = hz && !ex_flush && !mem_stall;
  assign stall_d  = stall_f;
  assign bubble_e = (hz || ex_flush) && !mem_stall;

  always_comb begin
    sel_a_d = 2'b00;
    sel_b_d = 2'b00;
    if (id_rs1_used && id_rs1 != '0) begin
      if (ex_prod && ex_rd == id_rs1)
        sel_a_d = 2'b10;
      else if (mem_prod && mem_rd == id_rs1)
        sel_a_d = 2'b01;
    end
    if (id_rs2_used && id_rs2 != '0) begin
      if (ex_prod && ex_rd == id_rs2)
        sel_b_d = 2'b10;
      else if (mem_prod && mem_rd == id_rs2)
        sel_b_d = 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_v      <= 1'b0;
      ex_rw     <= 1'b0;
      ex_mr     <= 1'b0;
      ex_rd     <= '0;
      mem_v     <= 1'b0;
      mem_rw    <= 1'b0;
      mem_rd    <= '0;
      fwd_a_sel <= 2'b00;
      fwd_b_sel <= 2'b00;
    end else if (adv) begin
      mem_v  <= ex_v;
      mem_rw <= ex_rw;
      mem_rd <= ex_rd;
      if (ex_load) begin
        ex_v      <= 1'b1;
        ex_rw     <= id_regwrite;
        ex_mr     <= id_memread;
        ex_rd     <= id_rd;
        fwd_a_sel <= sel_a_d;
        fwd_b_sel <= sel_b_d;
      end else begin
        ex_v      <= 1'b0;
        ex_rw     <= 1'b0;
        ex_mr     <= 1'b0;
        ex_rd     <= '0;
        fwd_a_sel <= 2'b00;
        fwd_b_sel <= 2'b00;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_inc = 1'b0;
    case (state_q)
      RUN: begin
        if (adv && hz && !ex_flush) begin
          state_d = LSTALL;
          cnt_inc = 1'b1;
        end
      end
      LSTALL: begin
        if (adv)
          state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      stall_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (cnt_inc && stall_cnt != '1)
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_fwd_ctrl.sv
// Scoreboard bench for alu_fwd_ctrl: directed pipeline scenarios plus random
// traffic, checked against an instruction-history model of the pipeline.
module tb_alu_fwd_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             id_valid = 1'b0;
  logic [REG_W-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic             id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic             id_regwrite = 1'b0, id_memread = 1'b0;
  logic             mem_stall = 1'b0, ex_flush = 1'b0;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic             stall_f, stall_d, bubble_e;
  logic [CNT_W-1:0] stall_cnt;

  alu_fwd_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .mem_stall(mem_stall), .ex_flush(ex_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .stall_f(stall_f), .stall_d(stall_d), .bubble_e(bubble_e),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             rw;
    logic             mr;
  } instr_t;

  typedef struct packed {
    logic [1:0]       sa;
    logic [1:0]       sb;
    logic             sf;
    logic             be;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  // hist holds what entered EX on each advancing edge, newest at the back.
  instr_t hist[$];
  exp_t   expq[$];
  logic [1:0] m_sa = 2'b00, m_sb = 2'b00;
  int     m_cnt = 0;
  int     checks = 0;
  int     failures = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic instr_t ago(input int d);
    instr_t none;
    none = '0;
    if (hist.size() >= d) return hist[hist.size()-d];
    return none;
  endfunction

  function automatic bit is_prod(input instr_t i);
    return i.v && i.rw && (i.rd != 0);
  endfunction

  // Youngest in-flight producer of s: one issue ago -> MEM path, two -> WB path.
  function automatic logic [1:0] model_sel(input logic used, input logic [REG_W-1:0] s);
    instr_t p;
    if (!used || s == 0) return 2'b00;
    for (int d = 1; d <= 2; d++) begin
      p = ago(d);
      if (is_prod(p) && p.rd == s) return (d == 1) ? 2'b10 : 2'b01;
    end
    return 2'b00;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_sa = 2'b00;
    m_sb = 2'b00;
    m_cnt = 0;
  endtask

  task automatic drive(input logic v, input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                       input logic u1, input logic u2, input logic [REG_W-1:0] rd,
                       input logic rw, input logic mr, input logic ms, input logic fl);
    instr_t ex, nw;
    bit hz;
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr; mem_stall = ms; ex_flush = fl;
    ex = ago(1);
    hz = v && is_prod(ex) && ex.mr && ((u1 && rs1 == ex.rd) || (u2 && rs2 == ex.rd));
    e.sa = m_sa;
    e.sb = m_sb;
    e.sf = hz && !fl && !ms;
    e.be = (hz || fl) && !ms;
    e.cnt = CNT_W'(m_cnt);
    expq.push_back(e);
    if (!ms) begin
      if (hz && !fl && m_cnt < (1 << CNT_W) - 1) m_cnt++;
      if (v && !hz && !fl) begin
        m_sa = model_sel(u1, rs1);
        m_sb = model_sel(u2, rs2);
        nw.v = 1'b1; nw.rd = rd; nw.rw = rw; nw.mr = mr;
      end else begin
        m_sa = 2'b00;
        m_sb = 2'b00;
        nw = '0;
      end
      hist.push_back(nw);
      if (hist.size() > 3) void'(hist.pop_front());
    end
  endtask

  task automatic alu(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2);
    drive(1, rs1, rs2, 1, 1, rd, 1, 0, 0, 0);
  endtask

  task automatic load(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs1);
    drive(1, rs1, 0, 1, 0, rd, 1, 1, 0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && expq.size() > 0) begin
        e = expq.pop_front();
        chk("fwd_a_sel", int'(fwd_a_sel), int'(e.sa));
        chk("fwd_b_sel", int'(fwd_b_sel), int'(e.sb));
        chk("stall_f", int'(stall_f), int'(e.sf));
        chk("stall_d", int'(stall_d), int'(e.sf));
        chk("bubble_e", int'(bubble_e), int'(e.be));
        chk("stall_cnt", int'(stall_cnt), int'(e.cnt));
      end
    end
  end

  initial begin : stim
    #12;
    chk("reset_sel_a", int'(fwd_a_sel), 0);
    chk("reset_sel_b", int'(fwd_b_sel), 0);
    chk("reset_stall_f", int'(stall_f), 0);
    chk("reset_bubble_e", int'(bubble_e), 0);
    chk("reset_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // EX->ID forward, then distance-2 and distance-3 producers
    alu(5, 1, 2);
    alu(6, 5, 5);
    alu(7, 1, 2);
    alu(10, 3, 3);
    alu(12, 7, 4);
    alu(11, 1, 1);
    alu(13, 2, 2);
    alu(14, 3, 3);
    alu(15, 11, 0);
    // load-use: one bubble, consumer then gets the WB path
    load(8, 1);
    alu(9, 8, 1);
    alu(9, 8, 1);
    alu(16, 2, 3);
    // load-use coinciding with a flush
    load(12, 2);
    drive(1, 12, 3, 1, 1, 17, 1, 0, 0, 1);
    alu(18, 12, 12);
    // load-use frozen by mem_stall for three cycles
    load(13, 3);
    for (int i = 0; i < 3; i++) drive(1, 2, 13, 1, 1, 19, 1, 0, 1, 0);
    drive(1, 2, 13, 1, 1, 19, 1, 0, 0, 0);
    drive(1, 2, 13, 1, 1, 19, 1, 0, 0, 0);
    // flush held through a memory stall
    alu(20, 1, 2);
    drive(1, 20, 20, 1, 1, 21, 1, 0, 1, 1);
    drive(1, 20, 20, 1, 1, 21, 1, 0, 1, 1);
    drive(1, 20, 20, 1, 1, 21, 1, 0, 0, 1);
    // x0 producers never forward or stall
    alu(0, 1, 2);
    alu(22, 0, 0);
    load(0, 1);
    alu(23, 0, 0);
    // idle ID, back-to-back loads to the same rd
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    load(14, 1);
    load(14, 2);
    alu(24, 14, 14);
    alu(24, 14, 14);
    alu(25, 14, 3);

    repeat (400) begin
      drive($urandom_range(0, 9) != 0, REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, REG_W'($urandom_range(0, 7)),
            $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0);
    end

    // reset asserted while a load-use hazard is pending
    load(26, 1);
    alu(27, 26, 26);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_sel_a", int'(fwd_a_sel), 0);
    chk("rst_sel_b", int'(fwd_b_sel), 0);
    chk("rst_stall_f", int'(stall_f), 0);
    chk("rst_stall_d", int'(stall_d), 0);
    chk("rst_bubble_e", int'(bubble_e), 0);
    chk("rst_cnt", int'(stall_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    alu(27, 26, 26);
    alu(28, 27, 1);
    alu(29, 27, 28);

    @(negedge clk);
    #1;
    chk("scoreboard_drained", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
